// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single tagged-word memory between two requesters.
//   Port 0 is the evaluator core and port 1 is the cons allocator / collector.
//   Requests are level-held. One port is served at a time, round-robin on
//   contention. Each transaction drives a one-cycle mem_req pulse, waits for
//   mem_ready and returns a one-cycle done pulse. A transaction is aborted with
//   err set when the memory does not answer within TIMEOUT cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN     requester N inputs, held stable until doneN
//   doneN/errN/rdataN         requester N completion pulse, timeout flag, read data
//   mem_req/mem_we            one-cycle memory request pulse and its write strobe
//   mem_addr/mem_wdata        address / write data, stable until completion
//   mem_ready/mem_rdata       memory completion pulse and read data
//   busy                      high whenever a transaction is in flight
//   grant                     index of the port being (or last) served
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  // Timer must be able to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              any_req_s;
  logic              sel_s;
  logic              answered_s;
  logic              expired_s;

  // Arbitration: a lone requester wins; on contention the port not served last wins.
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      sel_s = ~last_q;
    end else if (req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Completion conditions; mem_ready outside ISSUE/WAIT is deliberately ignored.
  always_comb begin
    answered_s = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && mem_ready;
    expired_s  = (state_q == S_WAIT) && !mem_ready && (timer_q == TIMEOUT_C);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = any_req_s ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = mem_ready ? S_DONE : S_WAIT;
      S_WAIT:  state_d = (answered_s || expired_s) ? S_DONE : S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are computed for the state being entered.
  always_comb begin
    last_d      = last_q;
    grant_d     = grant_q;
    we_d        = we_q;
    timer_d     = timer_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 2'b00;
    err_d       = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    busy_d      = (state_d != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          grant_d     = sel_s;
          we_d        = sel_s ? we1 : we0;
          mem_addr_d  = sel_s ? addr1 : addr0;
          mem_wdata_d = sel_s ? wdata1 : wdata0;
          mem_req_d   = 1'b1;
          mem_we_d    = sel_s ? we1 : we0;
          timer_d     = {TW{1'b0}};
        end else begin
          timer_d = timer_q;
        end
      end
      S_ISSUE: timer_d = {{(TW-1){1'b0}}, 1'b1};
      S_WAIT:  timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
      S_DONE:  last_d  = grant_q;
      default: timer_d = timer_q;
    endcase

    if (answered_s) begin
      done_d[grant_q] = 1'b1;
      // Writes complete without touching the requester's read data.
      if (!we_q) begin
        if (grant_q) begin
          rdata1_d = mem_rdata;
        end else begin
          rdata0_d = mem_rdata;
        end
      end else begin
        rdata0_d = rdata0_q;
      end
    end else if (expired_s) begin
      done_d[grant_q] = 1'b1;
      err_d[grant_q]  = 1'b1;
    end else begin
      done_d = 2'b00;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      timer_q     <= {TW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= {DATA_W{1'b0}};
      rdata1_q    <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule
